// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: ROB tag sizing, CDB entry layout, idle tag.
package ooo_pkg;

  // Tag 0 is reserved, so a ROB of N entries needs tags 1..N.
  function automatic int rob_tag_w(input int rob_size);
    return $clog2(rob_size + 1);
  endfunction

  localparam int ROB_SIZE     = 32;
  localparam int ROB_TAG_W    = rob_tag_w(ROB_SIZE);
  localparam int CDB_IDLE_TAG = 0;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic [63:0]          data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_broadcaster_if.sv
// FU result offers in, readiness back, registered tag/value broadcast out.
interface cdb_broadcaster_if
  import ooo_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = ROB_TAG_W
);
  logic [NUM_FU-1:0]             fuValid_i;
  logic [NUM_FU-1:0][TAG_W-1:0]  fuTag_i;
  logic [NUM_FU-1:0][63:0]       fuVal_i;
  logic [NUM_FU-1:0]             fuReady_o;
  logic [TAG_W-1:0]              issueROBTag_o;
  logic [64:0]                   issueROBval_o;

  modport master (
    output fuValid_i, fuTag_i, fuVal_i,
    input  fuReady_o, issueROBTag_o, issueROBval_o
  );

  modport slave (
    input  fuValid_i, fuTag_i, fuVal_i,
    output fuReady_o, issueROBTag_o, issueROBval_o
  );
endinterface

// File: rtl/cdb_result_fifo.sv
// Small per-FU result queue; clear empties it regardless of push/pop.
module cdb_result_fifo #(
  parameter int W     = 70,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wp, rp;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/cdb_broadcaster.sv
// Buffers FU results, picks one per cycle round-robin, drives a registered CDB.
module cdb_broadcaster
  import ooo_pkg::*;
#(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = rob_tag_w(ROBsize),
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  cdb_broadcaster_if.slave   bus,
  output logic               pending_o
);
  localparam int W   = ROBsizeLog + 64;
  localparam int RRW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic                          clr;
  logic [NUM_FU-1:0]             push, pop, full, empty;
  logic [NUM_FU-1:0][W-1:0]      head;
  logic [NUM_FU-1:0][CW-1:0]     count;
  logic [RRW-1:0]                rr, gnt_idx, idx, rr_nxt;
  logic                          gnt_vld;
  logic [W-1:0]                  win;

  // Reset and flush both empty every queue and drop same-cycle pushes.
  assign clr = ~reset_i | flush_i;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    // A tag-0 offer is a no-op: nothing is written and the count holds.
    assign push[k] = bus.fuValid_i[k] & ~full[k]
                   & (bus.fuTag_i[k] != ROBsizeLog'(CDB_IDLE_TAG));
    assign pop[k]  = gnt_vld & (gnt_idx == RRW'(k));

    cdb_result_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .push  (push[k]),
      .pop   (pop[k]),
      .clear (clr),
      .din   ({bus.fuTag_i[k], bus.fuVal_i[k]}),
      .dout  (head[k]),
      .count (count[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Readiness and pending come from registered counts only (no pop bypass).
  assign bus.fuReady_o = ~full;
  assign pending_o     = |count;

  // Round-robin scan starting at rr; first non-empty queue wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      idx = RRW'((int'(rr) + i) % NUM_FU);
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign rr_nxt = RRW'((int'(gnt_idx) + 1) % NUM_FU);
  assign win    = head[gnt_idx];

  // Output register: one-cycle broadcast of the winner, else idle 0/0.
  always_ff @(posedge clk_i) begin
    if (!reset_i || flush_i) begin
      rr                <= '0;
      bus.issueROBTag_o <= '0;
      bus.issueROBval_o <= '0;
    end else if (gnt_vld) begin
      rr                <= rr_nxt;
      bus.issueROBTag_o <= win[W-1:64];
      bus.issueROBval_o <= {1'b1, win[63:0]};
    end else begin
      bus.issueROBTag_o <= '0;
      bus.issueROBval_o <= '0;
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: single-push vector table plus multi-cycle sequences,
// with every broadcast matched against an in-order expected queue.
module tb_cdb_broadcaster;
  import ooo_pkg::*;

  localparam int NF = 4;
  localparam int TW = 6;

  logic clk_i = 1'b0;
  logic reset_i, flush_i, pending;
  int   checks = 0, failures = 0;
  cdb_entry_t sb[$];

  typedef struct {
    int          fu;
    cdb_entry_t  e;
    logic [TW-1:0] exp_tag;
    logic [64:0] exp_val;
    logic        exp_pend;
  } vec_t;
  vec_t vecs[5];

  cdb_broadcaster_if #(.NUM_FU(NF), .TAG_W(TW)) bus ();

  cdb_broadcaster #(.ROBsize(32), .NUM_FU(NF), .FIFO_DEPTH(2)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .bus       (bus),
    .pending_o (pending)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_bc(input logic [TW-1:0] tag, input logic [63:0] data);
    cdb_entry_t e;
    e.tag  = tag;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input int fu, input logic [TW-1:0] tag, input logic [63:0] data);
    bus.fuValid_i[fu] = 1'b1;
    bus.fuTag_i[fu]   = tag;
    bus.fuVal_i[fu]   = data;
  endtask

  task automatic idle_in();
    bus.fuValid_i = '0;
    bus.fuTag_i   = '0;
    bus.fuVal_i   = '0;
  endtask

  // One clock; afterwards any broadcast must be the next expected entry.
  task automatic tick();
    cdb_entry_t e;
    @(posedge clk_i);
    #1;
    if (bus.issueROBTag_o != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_bcast", 65'(bus.issueROBTag_o), 65'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_tag", 65'(bus.issueROBTag_o), 65'(e.tag));
        chk("sb_val", bus.issueROBval_o, {1'b1, e.data});
      end
    end else begin
      chk("idle_val", bus.issueROBval_o, 65'd0);
    end
  endtask

  initial begin
    vecs[0] = '{2, '{6'd5,  64'hDEAD_BEEF},            6'd5,  65'h1_0000_0000_DEAD_BEEF, 1'b1};
    vecs[1] = '{3, '{6'd0,  64'h1234},                 6'd0,  65'h0,                      1'b0};
    vecs[2] = '{0, '{6'd32, 64'hFFFF_FFFF_FFFF_FFFF},  6'd32, 65'h1_FFFF_FFFF_FFFF_FFFF,  1'b1};
    vecs[3] = '{1, '{6'd63, 64'h0},                    6'd63, 65'h1_0000_0000_0000_0000,  1'b1};
    vecs[4] = '{3, '{6'd1,  64'h0123_4567_89AB_CDEF},  6'd1,  65'h1_0123_4567_89AB_CDEF,  1'b1};

    // Reset held with all FUs offering: nothing may be queued.
    idle_in();
    flush_i = 1'b0;
    reset_i = 1'b0;
    for (int k = 0; k < NF; k++) drive(k, TW'(k + 1), 64'(k + 100));
    tick();
    tick();
    chk("rst_tag",   65'(bus.issueROBTag_o), 65'd0);
    chk("rst_val",   bus.issueROBval_o, 65'd0);
    chk("rst_ready", 65'(bus.fuReady_o), 65'hF);
    chk("rst_pend",  65'(pending), 65'd0);
    idle_in();
    reset_i = 1'b1;
    repeat (3) tick();

    // Single pushes: latency, value format, tag-0 drop.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].exp_tag != '0) expect_bc(vecs[v].e.tag, vecs[v].e.data);
      drive(vecs[v].fu, vecs[v].e.tag, vecs[v].e.data);
      tick();
      idle_in();
      chk("vec_pend", 65'(pending), 65'(vecs[v].exp_pend));
      tick();
      chk("vec_tag", 65'(bus.issueROBTag_o), 65'(vecs[v].exp_tag));
      chk("vec_val", bus.issueROBval_o, vecs[v].exp_val);
      tick();
      chk("vec_idle", 65'(bus.issueROBTag_o), 65'd0);
    end

    // Contention: two back-to-back bursts drain in round-robin order, no gaps.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int k = 0; k < NF; k++) begin
      expect_bc(TW'(k + 1), 64'(256 + k));
      drive(k, TW'(k + 1), 64'(256 + k));
    end
    tick();
    for (int k = 0; k < NF; k++) begin
      expect_bc(TW'(k + 5), 64'(512 + k));
      drive(k, TW'(k + 5), 64'(512 + k));
    end
    tick();
    idle_in();
    repeat (7) tick();
    chk("burst_drained", 65'(sb.size()), 65'd0);
    tick();
    chk("burst_idle", 65'(bus.issueROBTag_o), 65'd0);

    // Backpressure: FU1 fills, third offer waits for a freed slot.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    expect_bc(6'd10, 64'hA0);
    expect_bc(6'd21, 64'hB1);
    expect_bc(6'd11, 64'hA1);
    expect_bc(6'd22, 64'hB2);
    expect_bc(6'd12, 64'hA2);
    expect_bc(6'd23, 64'hB3);
    drive(0, 6'd10, 64'hA0);
    drive(1, 6'd21, 64'hB1);
    tick();
    drive(0, 6'd11, 64'hA1);
    drive(1, 6'd22, 64'hB2);
    tick();
    chk("bp_ready1_full", 65'(bus.fuReady_o[1]), 65'd0);
    drive(0, 6'd12, 64'hA2);
    drive(1, 6'd23, 64'hB3);
    tick();
    chk("bp_ready1_free", 65'(bus.fuReady_o[1]), 65'd1);
    chk("bp_ready0_full", 65'(bus.fuReady_o[0]), 65'd0);
    bus.fuValid_i[0] = 1'b0;
    tick();
    idle_in();
    repeat (4) tick();
    chk("bp_drained", 65'(sb.size()), 65'd0);

    // Flush with three queued: none emitted, pending drops, rr back to 0.
    drive(0, 6'd40, 64'h40);
    drive(1, 6'd41, 64'h41);
    drive(2, 6'd42, 64'h42);
    tick();
    idle_in();
    chk("fl_pend_before", 65'(pending), 65'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_tag", 65'(bus.issueROBTag_o), 65'd0);
    chk("fl_pend_after", 65'(pending), 65'd0);
    repeat (3) tick();
    expect_bc(6'd50, 64'h50);
    expect_bc(6'd53, 64'h53);
    drive(0, 6'd50, 64'h50);
    drive(3, 6'd53, 64'h53);
    tick();
    idle_in();
    repeat (3) tick();
    chk("fl_rr_order", 65'(sb.size()), 65'd0);

    // Reset while tag 7 is queued for broadcast: it must never appear.
    drive(0, 6'd7, 64'h77);
    drive(1, 6'd9, 64'h99);
    tick();
    idle_in();
    chk("mr_pend_before", 65'(pending), 65'd1);
    reset_i = 1'b0;
    tick();
    chk("mr_tag",   65'(bus.issueROBTag_o), 65'd0);
    chk("mr_val",   bus.issueROBval_o, 65'd0);
    chk("mr_pend",  65'(pending), 65'd0);
    chk("mr_ready", 65'(bus.fuReady_o), 65'hF);
    reset_i = 1'b1;
    repeat (4) tick();
    chk("final_sb_empty", 65'(sb.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
